action_sequencer: RTL and testbench

Driver side of the fightingGame action interface. It queues per-player button codes and, on a fixed round timer, presents one action per player on action1/action2 with a one-cycle actionEnable strobe. It watches firstWin/secondWin and stops issuing once the game is decided. It sits between the player input logic and fightingGame, and drives that block's action1, action2 and actionEnable inputs.

---
 rtl/action_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_action_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_sequencer.sv
// Round-timed action issuer for fightingGame: per-player FIFO of button codes,
// one action pair popped and strobed every ROUND_CYCLES cycles until a win.

module action_queue #(
  parameter int         DEPTH       = 4,
  parameter logic [2:0] IDLE_ACTION = 3'b000
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [2:0]                 i_code,
  input  logic                       i_pop,
  output logic [2:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [2:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  // An empty queue pops nothing (the head reads IDLE_ACTION); a full queue
  // being popped frees the slot the push lands in.
  assign w_pop   = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || i_pop);
  assign o_head  = w_empty ? IDLE_ACTION : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr && !i_rst && !i_flush) begin
      r_mem[r_wptr] <= i_code;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
      if (i_push && w_full && !i_pop) r_overflow <= 1'b1;
    end
  end

  assign o_level    = r_level;
  assign o_overflow = r_overflow;
endmodule

// Pushes are fire-and-forget: btn_validN has no ready; a push that finds the
// queue full (and not popped that cycle) is dropped and latches overflowN.
module action_sequencer #(
  parameter int         ROUND_CYCLES = 4,
  parameter int         DEPTH        = 4,
  parameter logic [2:0] IDLE_ACTION  = 3'b000
) (
  input  logic                       clk,
  input  logic                       resetGame,
  input  logic                       start,
  input  logic                       btn_valid1,
  input  logic [2:0]                 btn_code1,
  input  logic                       btn_valid2,
  input  logic [2:0]                 btn_code2,
  input  logic                       firstWin,
  input  logic                       secondWin,
  output logic [2:0]                 action1,
  output logic [2:0]                 action2,
  output logic                       actionEnable,
  output logic [$clog2(DEPTH+1)-1:0] level1,
  output logic [$clog2(DEPTH+1)-1:0] level2,
  output logic                       overflow1,
  output logic                       overflow2,
  output logic [7:0]                 round_count,
  output logic [1:0]                 o_state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_RELOAD = 8'(ROUND_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nx;
  logic [7:0] r_timer;
  logic [7:0] w_timer_nx;
  logic [2:0] r_action1;
  logic [2:0] r_action2;
  logic       r_enable;
  logic [7:0] r_round;

  logic       w_win;
  logic       w_issue;
  logic       w_push_ok;
  logic       w_flush;
  logic [2:0] w_head1;
  logic [2:0] w_head2;

  assign w_win = firstWin || secondWin;

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_issue    = 1'b0;
    w_push_ok  = 1'b0;
    w_flush    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_push_ok = 1'b1;
        if (start) begin
          w_state_nx = S_RUN;
          w_timer_nx = TIMER_RELOAD;
        end
      end
      S_RUN: begin
        // A win suppresses any issue due at the same edge.
        if (w_win) begin
          w_state_nx = S_HALT;
          w_flush    = 1'b1;
        end else begin
          w_push_ok = 1'b1;
          if (r_timer == 8'd0) begin
            w_issue    = 1'b1;
            w_timer_nx = TIMER_RELOAD;
          end else begin
            w_timer_nx = r_timer - 8'd1;
          end
        end
      end
      S_HALT: begin
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetGame) begin
      r_state   <= S_IDLE;
      r_timer   <= 8'd0;
      r_action1 <= 3'b000;
      r_action2 <= 3'b000;
      r_enable  <= 1'b0;
      r_round   <= 8'd0;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      r_enable <= w_issue;
      if (w_issue) begin
        r_action1 <= w_head1;
        r_action2 <= w_head2;
        r_round   <= r_round + 8'd1;
      end
    end
  end

  action_queue #(.DEPTH(DEPTH), .IDLE_ACTION(IDLE_ACTION)) u_q1 (
    .clk       (clk),
    .i_rst     (resetGame),
    .i_flush   (w_flush),
    .i_push    (btn_valid1 && w_push_ok),
    .i_code    (btn_code1),
    .i_pop     (w_issue),
    .o_head    (w_head1),
    .o_level   (level1),
    .o_overflow(overflow1)
  );

  action_queue #(.DEPTH(DEPTH), .IDLE_ACTION(IDLE_ACTION)) u_q2 (
    .clk       (clk),
    .i_rst     (resetGame),
    .i_flush   (w_flush),
    .i_push    (btn_valid2 && w_push_ok),
    .i_code    (btn_code2),
    .i_pop     (w_issue),
    .o_head    (w_head2),
    .o_level   (level2),
    .o_overflow(overflow2)
  );

  assign action1      = r_action1;
  assign action2      = r_action2;
  assign actionEnable = r_enable;
  assign round_count  = r_round;
  assign o_state_dbg  = r_state;
endmodule

// File: tb/tb_action_sequencer.sv
// Bench for action_sequencer: directed plan scenarios with literal checks, then
// random traffic, all compared every cycle against a queue-based model.

module tb_action_sequencer;
  localparam int         RC    = 4;
  localparam int         DEPTH = 4;
  localparam logic [2:0] IDLE  = 3'b000;
  localparam int         LW    = $clog2(DEPTH+1);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetGame = 1'b1;
  logic          start = 1'b0;
  logic          btn_valid1 = 1'b0, btn_valid2 = 1'b0;
  logic [2:0]    btn_code1 = 3'b0, btn_code2 = 3'b0;
  logic          firstWin = 1'b0, secondWin = 1'b0;
  logic [2:0]    action1, action2;
  logic          actionEnable;
  logic [LW-1:0] level1, level2;
  logic          overflow1, overflow2;
  logic [7:0]    round_count;
  logic [1:0]    state_dbg;

  action_sequencer #(.ROUND_CYCLES(RC), .DEPTH(DEPTH), .IDLE_ACTION(IDLE)) dut (
    .clk(clk), .resetGame(resetGame), .start(start),
    .btn_valid1(btn_valid1), .btn_code1(btn_code1),
    .btn_valid2(btn_valid2), .btn_code2(btn_code2),
    .firstWin(firstWin), .secondWin(secondWin),
    .action1(action1), .action2(action2), .actionEnable(actionEnable),
    .level1(level1), .level2(level2),
    .overflow1(overflow1), .overflow2(overflow2),
    .round_count(round_count), .o_state_dbg(state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode 0 idle, 1 running, 2 halted. Issues happen at absolute edge numbers
  // start_edge + n*RC rather than via a down-counter.
  logic [2:0] q1[$];
  logic [2:0] q2[$];
  int         m_mode = 0;
  logic [2:0] m_a1 = 0, m_a2 = 0;
  logic       m_en = 0, m_ov1 = 0, m_ov2 = 0;
  logic [7:0] m_rc = 0;
  int         m_next = 0;
  int         cyc = 0;
  bit         model_ok = 0;

  task automatic model_push(input logic v1, input logic [2:0] c1,
                            input logic v2, input logic [2:0] c2);
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(c1); else m_ov1 = 1'b1;
    end
    if (v2) begin
      if (q2.size() < DEPTH) q2.push_back(c2); else m_ov2 = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (resetGame) begin
      q1.delete(); q2.delete();
      m_mode = 0; m_a1 = 0; m_a2 = 0; m_en = 0; m_rc = 0;
      m_ov1 = 0; m_ov2 = 0; model_ok = 1;
    end else if (model_ok) begin
      m_en = 0;
      if (m_mode == 0) begin
        model_push(btn_valid1, btn_code1, btn_valid2, btn_code2);
        if (start) begin
          m_mode = 1;
          m_next = cyc + RC;
        end
      end else if (m_mode == 1) begin
        if (firstWin || secondWin) begin
          m_mode = 2;
          q1.delete(); q2.delete();
        end else begin
          if (cyc == m_next) begin
            m_a1 = (q1.size() > 0) ? q1.pop_front() : IDLE;
            m_a2 = (q2.size() > 0) ? q2.pop_front() : IDLE;
            m_en = 1;
            m_rc = m_rc + 8'd1;
            m_next = m_next + RC;
          end
          model_push(btn_valid1, btn_code1, btn_valid2, btn_code2);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_action1", action1, m_a1);
      check("m_action2", action2, m_a2);
      check("m_enable", actionEnable, m_en);
      check("m_level1", level1, q1.size());
      check("m_level2", level2, q2.size());
      check("m_ovf1", overflow1, m_ov1);
      check("m_ovf2", overflow2, m_ov2);
      check("m_round", round_count, m_rc);
      check("m_state", state_dbg, m_mode);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetGame = 1'b1; tick(); tick(); resetGame = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_strobe(output int waited);
    waited = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (actionEnable === 1'b1) begin
        waited = i;
        break;
      end
    end
    if (waited == 0) check("strobe_timeout", 0, 1);
  endtask

  // ---------------- directed plan + random traffic ----------------
  initial begin
    int w;
    logic [2:0] exp3;

    // 1: reset then empty-queue rounds
    tick(); tick();
    check("rst_action1", action1, 0);
    check("rst_enable", actionEnable, 0);
    check("rst_round", round_count, 0);
    check("rst_levels", {level1, level2}, 0);
    check("rst_state", state_dbg, 0);
    resetGame = 1'b0;
    pulse_start();
    for (int r = 1; r <= 3; r++) begin
      wait_strobe(w);
      check("t1_spacing", w, RC);
      check("t1_round", round_count, r);
      check("t1_actions", {action1, action2}, 6'b000000);
    end

    // 2: basic issue
    do_reset();
    btn_valid1 = 1; btn_code1 = 3'b110; btn_valid2 = 1; btn_code2 = 3'b100;
    tick();
    btn_valid1 = 0; btn_valid2 = 0;
    check("t2_level1_pre", level1, 1);
    pulse_start();
    wait_strobe(w);
    check("t2_latency", w, RC);
    check("t2_action1", action1, 3'b110);
    check("t2_action2", action2, 3'b100);
    check("t2_levels", {level1, level2}, 0);
    tick();
    check("t2_single_strobe", actionEnable, 0);
    check("t2_hold", action1, 3'b110);
    wait_strobe(w);
    check("t2_second", {action1, action2}, 6'b000000);

    // 3: overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      btn_valid1 = 1; btn_code1 = 3'(i + 1); tick();
    end
    btn_valid1 = 0;
    check("t3_level1", level1, 4);
    check("t3_ovf1", overflow1, 1);
    check("t3_ovf2", overflow2, 0);
    pulse_start();
    for (int r = 0; r < 5; r++) begin
      wait_strobe(w);
      exp3 = (r < 4) ? 3'(r + 1) : 3'b000;
      check("t3_seq", action1, exp3);
    end

    // 4: full queue push at the issue edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      btn_valid1 = 1; btn_code1 = 3'(i + 1); tick();
    end
    btn_valid1 = 0;
    pulse_start();
    tick(); tick(); tick();
    btn_valid1 = 1; btn_code1 = 3'b111;
    tick();
    btn_valid1 = 0;
    check("t4_strobe", actionEnable, 1);
    check("t4_first", action1, 3'b001);
    check("t4_level1", level1, 4);
    check("t4_ovf1", overflow1, 0);
    for (int r = 0; r < 4; r++) wait_strobe(w);
    check("t4_late", action1, 3'b111);

    // 5: win halt on the issue edge
    do_reset();
    btn_valid1 = 1; btn_code1 = 3'b101; btn_valid2 = 1; btn_code2 = 3'b011;
    tick();
    btn_valid1 = 0; btn_valid2 = 0;
    pulse_start();
    tick(); tick(); tick();
    secondWin = 1;
    tick();
    secondWin = 0;
    check("t5_no_strobe", actionEnable, 0);
    check("t5_round", round_count, 0);
    check("t5_levels", {level1, level2}, 0);
    check("t5_state", state_dbg, 2);
    btn_valid1 = 1; start = 1; tick(); tick();
    btn_valid1 = 0; start = 0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_ignore_level", level1, 0);
    check("t5_ignore_state", state_dbg, 2);
    check("t5_ignore_round", round_count, 0);
    do_reset();
    check("t5_back_idle", state_dbg, 0);

    // 6: reset on the cycle a strobe is due
    btn_valid1 = 1; btn_code1 = 3'b010; tick(); btn_valid1 = 0;
    pulse_start();
    tick(); tick(); tick();
    resetGame = 1;
    tick();
    resetGame = 0;
    check("t6_enable", actionEnable, 0);
    check("t6_action1", action1, 0);
    check("t6_level1", level1, 0);
    check("t6_round", round_count, 0);
    check("t6_state", state_dbg, 0);

    // random traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      btn_valid1 = ($urandom_range(0, 99) < 40);
      btn_code1  = 3'($urandom_range(0, 7));
      btn_valid2 = ($urandom_range(0, 99) < 30);
      btn_code2  = 3'($urandom_range(0, 7));
      start      = ($urandom_range(0, 99) < 5);
      firstWin   = ($urandom_range(0, 999) < 8);
      secondWin  = ($urandom_range(0, 999) < 8);
      resetGame  = ($urandom_range(0, 999) < 6);
      tick();
    end
    btn_valid1 = 0; btn_valid2 = 0; start = 0;
    firstWin = 0; secondWin = 0; resetGame = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
